// File: rtl/pulse_monitor_pkg.sv
// pulse_monitor_pkg: shared definitions for the pulse width monitor.
//   - default values for the WIDTH_W / MIN_WIDTH / MAX_WIDTH parameters
//   - 2-bit FSM state encoding used by pulse_monitor
package pulse_monitor_pkg;

    localparam int WIDTH_W_DEF   = 8;
    localparam int MIN_WIDTH_DEF = 2;
    localparam int MAX_WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,  // after reset: wait until the input is seen low
        IDLE     = 2'd1,  // armed, waiting for a rising input
        MEASURE  = 2'd2,  // counting high samples
        REPORT   = 2'd3   // one-cycle result strobe
    } state_e;

endpackage

// File: rtl/pulse_monitor_if.sv
// pulse_monitor_if: result bus of the pulse width monitor.
//   width_out    measured width of the last completed pulse
//   width_valid  one-cycle strobe qualifying width_out and the flags
//   too_short    width_out < MIN_WIDTH   (valid with width_valid)
//   too_long     width_out > MAX_WIDTH   (valid with width_valid)
//   overflow     counter saturated during the pulse (valid with width_valid)
//   pulse_count  completed pulses, modulo 256
//   busy         a pulse is being measured
// modport master: driven by pulse_monitor; modport slave: result consumer.
interface pulse_monitor_if
    import pulse_monitor_pkg::*;
#(
    parameter int WIDTH_W = WIDTH_W_DEF
);
    logic [WIDTH_W-1:0] width_out;
    logic               width_valid;
    logic               too_short;
    logic               too_long;
    logic               overflow;
    logic [7:0]         pulse_count;
    logic               busy;

    modport master (
        output width_out, width_valid, too_short, too_long, overflow,
               pulse_count, busy
    );

    modport slave (
        input  width_out, width_valid, too_short, too_long, overflow,
               pulse_count, busy
    );
endinterface

// File: rtl/pulse_sync.sv
// pulse_sync: two-flop synchronizer for the asynchronous pulse input.
//   clk    sampling clock
//   reset  synchronous, active-high; both flops reset to 1 so that a pulse
//          already high at reset release is not mistaken for a new rising edge
//   d      asynchronous input
//   q      synchronized output
module pulse_sync
    import pulse_monitor_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pulse_monitor.sv
// pulse_monitor: measures the width (in clk cycles) of pulses on an
// asynchronous input and reports each completed pulse on the result bus.
//   clk       single clock, rising edge
//   reset     synchronous, active-high
//   pulse_in  asynchronous pulse input
//   mon       result bus (pulse_monitor_if.master)
// Width equals the number of rising clk edges at which pulse_in was high.
// The counter saturates at 2^WIDTH_W-1 and raises overflow in that case.
module pulse_monitor
    import pulse_monitor_pkg::*;
#(
    parameter int WIDTH_W   = WIDTH_W_DEF,
    parameter int MIN_WIDTH = MIN_WIDTH_DEF,
    parameter int MAX_WIDTH = MAX_WIDTH_DEF
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            pulse_in,
    pulse_monitor_if.master mon
);
    localparam logic [WIDTH_W-1:0] CNT_MAX = '1;
    localparam logic [WIDTH_W-1:0] MIN_W   = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0] MAX_W   = WIDTH_W'(MAX_WIDTH);
    localparam logic [WIDTH_W-1:0] CNT_ONE = WIDTH_W'(1);

    logic               s_q;
    state_e             state_q, state_d;
    logic [WIDTH_W-1:0] cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               enter_report;

    pulse_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pulse_in),
        .q     (s_q)
    );

    // Next state / counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            WAIT_LOW: begin
                if (!s_q) state_d = IDLE;
            end
            IDLE: begin
                if (s_q) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                    sat_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (s_q) begin
                    // Hold at full scale; remember that samples were lost.
                    if (cnt_q == CNT_MAX) sat_d = 1'b1;
                    else                  cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                // A single low cycle between pulses is enough: restart here.
                if (s_q) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                    sat_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    assign enter_report = (state_q == MEASURE) && !s_q;

    // State and registered outputs; strobes are high exactly while in REPORT
    // and busy exactly while in MEASURE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= WAIT_LOW;
            cnt_q           <= '0;
            sat_q           <= 1'b0;
            mon.width_out   <= '0;
            mon.width_valid <= 1'b0;
            mon.too_short   <= 1'b0;
            mon.too_long    <= 1'b0;
            mon.overflow    <= 1'b0;
            mon.pulse_count <= '0;
            mon.busy        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sat_q           <= sat_d;
            mon.width_valid <= enter_report;
            mon.too_short   <= enter_report && (cnt_q < MIN_W);
            mon.too_long    <= enter_report && (cnt_q > MAX_W);
            mon.overflow    <= enter_report && sat_q;
            mon.busy        <= (state_d == MEASURE);
            if (enter_report) begin
                mon.width_out   <= cnt_q;
                mon.pulse_count <= mon.pulse_count + 8'd1;
            end
        end
    end
endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 SHALL have parameter WIDTH_W, default 8: width of the measurement counter and width_out.
REQ-002 SHALL have parameter MIN_WIDTH, default 2: shortest legal pulse, in clk cycles.
REQ-003 SHALL have parameter MAX_WIDTH, default 3: longest legal pulse, in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pulse_in, input, 1 bit: asynchronous pulse from the upstream pulse generator.
REQ-007 SHALL have port width_out, output, WIDTH_W bits: measured width of the last completed pulse.
REQ-008 SHALL have port width_valid, output, 1 bit: one-cycle strobe qualifying width_out and the flags.
REQ-009 SHALL have port too_short, output, 1 bit: width_out < MIN_WIDTH; valid with width_valid.
REQ-010 SHALL have port too_long, output, 1 bit: width_out > MAX_WIDTH; valid with width_valid.
REQ-011 SHALL have port overflow, output, 1 bit: the counter saturated during the pulse; valid with width_valid.
REQ-012 SHALL have port pulse_count, output, 8 bits: number of completed pulses, modulo 256.
REQ-013 SHALL have port busy, output, 1 bit: high while a pulse is being measured.

Function
REQ-014 SHALL pass pulse_in through a two-flop synchronizer; its output is called s_q.
REQ-015 SHALL implement FSM states WAIT_LOW, IDLE, MEASURE, REPORT.
REQ-016 In WAIT_LOW: go to IDLE on the first edge with s_q=0; no measurement takes place.
REQ-017 In IDLE: on s_q=1, go to MEASURE with counter <= 1; otherwise stay in IDLE.
REQ-018 In MEASURE: on s_q=1, counter <= counter+1, saturating at 2^WIDTH_W-1 and setting an internal sat flag.
REQ-019 In MEASURE: on s_q=0, go to REPORT, latch width_out <= counter, and drive all flags.
REQ-020 REPORT SHALL last exactly one cycle: go to MEASURE with counter <= 1 if s_q=1, else to IDLE.
REQ-021 Reported width SHALL equal the number of rising clk edges at which pulse_in was sampled high.
REQ-022 Latency: width_valid asserts in the cycle after the second edge following the first low sample of pulse_in.
REQ-023 width_valid, too_short, too_long and overflow SHALL be high only in REPORT, and are 0 otherwise.
REQ-024 width_out SHALL hold its value until the next REPORT.
REQ-025 pulse_count SHALL increment by 1 on each entry to REPORT and wrap 255 -> 0.
REQ-026 busy SHALL equal 1 exactly when the state is MEASURE.
REQ-027 A minimum gap of 1 low cycle between pulses SHALL be measured correctly, with no pulse lost.
REQ-028 With MIN_WIDTH <= width <= MAX_WIDTH, both too_short and too_long SHALL be 0.

Reset
REQ-029 While reset=1 at an edge: state <= WAIT_LOW, both synchronizer flops <= 1, counter <= 0, sat <= 0.
REQ-030 While reset=1 at an edge: width_out <= 0, pulse_count <= 0, and all strobes and busy <= 0.
REQ-031 Reset SHALL override all other activity, including mid-pulse.
REQ-032 A pulse already high at reset release SHALL be ignored entirely.

Structure
REQ-033 Package pulse_monitor_pkg SHALL hold the FSM state encoding (2 bits) and the default values of WIDTH_W, MIN_WIDTH and MAX_WIDTH.
REQ-034 The synchronizer SHALL be a separate sub-module pulse_sync: 2 flops, reset value 1.
REQ-035 All other logic SHALL be in pulse_monitor: FSM, counter and output registers.

Verification
REQ-036 Reset for 3 cycles with pulse_in=0, then 5 idle cycles -> all outputs 0, no width_valid.
REQ-037 pulse_in high for 3 edges -> one width_valid strobe, width_out=3, all flags 0, pulse_count=1.
REQ-038 1-edge pulse -> width_out=1, too_short=1; then a 5-edge pulse -> width_out=5, too_long=1, pulse_count=2.
REQ-039 pulse_in high for 300 edges -> width_out=255, overflow=1, too_long=1, busy high throughout.
REQ-040 Pattern high 2 / low 1 / high 2 -> two strobes, each width_out=2, pulse_count=2.
REQ-041 Reset asserted mid-pulse with pulse_in still high, released while high -> no strobe for that pulse; the next 3-edge pulse reports 3.
